// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the I/O controller and its sub-modules.
//   io_state_t : states of the input-instruction handshake FSM
//   DATA_W_DEF : default processor data word width
//   EXT_FN     : how the switch word is widened onto DataIn
// Build option: IO_SIGN_EXT_EN selects sign extension of the switches
// (bit SW_W-1 replicated); left undefined, the switches are zero-extended.
package io_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT_PRESS,
      DONE
   } io_state_t;

   typedef enum logic {
      EXT_ZERO,
      EXT_SIGN
   } ext_fn_t;

`ifdef IO_SIGN_EXT_EN
   localparam ext_fn_t EXT_FN = EXT_SIGN;
`else
   localparam ext_fn_t EXT_FN = EXT_ZERO;
`endif

endpackage

// File: rtl/io_debounce.sv
// io_debounce: conditions the raw Enter push-button.
//   clock     in  system clock, posedge
//   reset_n   in  asynchronous active-low reset
//   btn_raw   in  raw asynchronous button, active-high
//   btn_db    out debounced button level
//   btn_rise  out one-cycle pulse on a 0->1 change of btn_db
// The raw input passes a 2-flop synchroniser. btn_db follows the
// synchronised sample only after DEBOUNCE_CYCLES consecutive samples
// disagree with it; any agreeing sample restarts the count.
module io_debounce #(
   parameter  int DEBOUNCE_CYCLES = 50000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             btn_db_reg;
   logic             rise_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         cnt_reg    <= '0;
         btn_db_reg <= 1'b0;
         rise_reg   <= 1'b0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == btn_db_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th disagreeing sample: accept it.
            cnt_reg    <= '0;
            btn_db_reg <= sync2_reg;
            rise_reg   <= sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign btn_db   = btn_db_reg;
   assign btn_rise = rise_reg;

endmodule

// File: rtl/io_controller.sv
// io_controller: peripheral side of the register bank's I/O path.
//   clock          in  system clock, posedge
//   reset_n        in  asynchronous active-low reset
//   outputControl  in  output-instruction strobe (also sampled by the bank)
//   OutData        in  bank result word, valid the cycle after the strobe
//   InReq          in  input-instruction request, level
//   Switches       in  raw board switches
//   EnterBtn       in  raw Enter button, active-high
//   Stall          out freeze PC/pipeline while an input is pending
//   InputReady     out one-cycle strobe to the bank's inputControl
//   DataIn         out captured switch word, held after InputReady
//   Display        out last output word
//   DisplayValid   out sticky, set by the first output
// Build option: IO_SIGN_EXT_EN (see io_pkg) sign-extends Switches onto
// DataIn instead of zero-extending.
module io_controller
   import io_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEF,
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              outputControl,
   input  logic [DATA_W-1:0] OutData,
   input  logic              InReq,
   input  logic [SW_W-1:0]   Switches,
   input  logic              EnterBtn,
   output logic              Stall,
   output logic              InputReady,
   output logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] Display,
   output logic              DisplayValid
);

   io_state_t         state_reg, state_next;
   logic              capture;
   logic              btn_db;
   logic              btn_rise;
   logic [DATA_W-1:0] sw_ext;
   logic [DATA_W-1:0] data_in_reg;
   logic              out_d_reg;
   logic [DATA_W-1:0] display_reg;
   logic              display_valid_reg;

   io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock    (clock),
      .reset_n  (reset_n),
      .btn_raw  (EnterBtn),
      .btn_db   (btn_db),
      .btn_rise (btn_rise)
   );

   // Widen the switch word bit by bit; upper bits are either the switch
   // MSB or zero depending on the build option.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_ext
         if (gi < SW_W) begin : g_sw
            assign sw_ext[gi] = Switches[gi];
         end else if (EXT_FN == EXT_SIGN) begin : g_sign
            assign sw_ext[gi] = Switches[SW_W-1];
         end else begin : g_zero
            assign sw_ext[gi] = 1'b0;
         end
      end
   endgenerate

   // Output path: the bank updates OutData on the edge that samples the
   // strobe, so the strobe is delayed one cycle before latching OutData.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_d_reg         <= 1'b0;
         display_reg       <= '0;
         display_valid_reg <= 1'b0;
      end else begin
         out_d_reg <= outputControl;
         if (out_d_reg) begin
            display_reg       <= OutData;
            display_valid_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         data_in_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            data_in_reg <= sw_ext;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      Stall      = 1'b0;
      InputReady = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            // Stall in the request cycle itself; gated by reset_n so that
            // a reset forces Stall low even while InReq is still high.
            Stall = InReq & reset_n;
            if (InReq) begin
               state_next = ARM;
            end
         end
         ARM: begin
            // A button already held when the instruction arrives must be
            // released before a press can count.
            Stall = 1'b1;
            if (!InReq) begin
               state_next = IDLE;
            end else if (!btn_db) begin
               state_next = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            Stall = 1'b1;
            if (!InReq) begin
               state_next = IDLE;
            end else if (btn_rise) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            InputReady = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign DataIn       = data_in_reg;
   assign Display      = display_reg;
   assign DisplayValid = display_valid_reg;

endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed plus randomized checks of io_controller with
// DEBOUNCE_CYCLES=4. Expected values come from a transaction-level model:
// the display shows the last output word, DataIn shows the widened switch
// word of the last accepted press, and each accepted press gives one pulse.
module tb_io_controller;

   localparam int DATA_W = 32;
   localparam int SW_W   = 16;
   localparam int DB     = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              outputControl;
   logic [DATA_W-1:0] OutData;
   logic              InReq;
   logic [SW_W-1:0]   Switches;
   logic              EnterBtn;
   logic              Stall;
   logic              InputReady;
   logic [DATA_W-1:0] DataIn;
   logic [DATA_W-1:0] Display;
   logic              DisplayValid;

   int n_pass   = 0;
   int n_total  = 0;
   int ir_count = 0;

   logic [DATA_W-1:0] exp_display;
   logic [DATA_W-1:0] exp_datain;

   io_controller #(
      .DATA_W          (DATA_W),
      .SW_W            (SW_W),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .outputControl (outputControl),
      .OutData       (OutData),
      .InReq         (InReq),
      .Switches      (Switches),
      .EnterBtn      (EnterBtn),
      .Stall         (Stall),
      .InputReady    (InputReady),
      .DataIn        (DataIn),
      .Display       (Display),
      .DisplayValid  (DisplayValid)
   );

   always #5 clock = ~clock;

   // Counts every InputReady pulse seen away from the active edge.
   always @(negedge clock) begin
      if (reset_n && InputReady) ir_count++;
   end

   function automatic logic [DATA_W-1:0] ext_sw(input logic [SW_W-1:0] sw);
`ifdef IO_SIGN_EXT_EN
      return {{(DATA_W-SW_W){sw[SW_W-1]}}, sw};
`else
      return {{(DATA_W-SW_W){1'b0}}, sw};
`endif
   endfunction

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One output instruction: strobe for a cycle, bank presents the word
   // on the following cycle, display follows one cycle later.
   task automatic do_output(input logic [DATA_W-1:0] data);
      outputControl = 1'b1;
      step(1);
      outputControl = 1'b0;
      OutData       = data;
      @(negedge clock);
      chk("display_before_latch", Display, exp_display);
      step(1);
      @(negedge clock);
      exp_display = data;
      chk("display", Display, exp_display);
      chk("display_valid", {31'b0, DisplayValid}, 32'd1);
      $display("txn output data=%h display=%h", data, Display);
   endtask

   task automatic start_input(input logic [SW_W-1:0] sw);
      Switches = sw;
      InReq    = 1'b1;
      #1;
      chk("stall_on_request", {31'b0, Stall}, 32'd1);
   endtask

   // Press the button for 'hold' cycles with an input pending and expect
   // exactly one InputReady carrying exp.
   task automatic press_and_wait(input int hold, input logic [DATA_W-1:0] exp,
                                 input string tag);
      int   start;
      int   held;
      logic got;
      logic stall_bad;
      start     = ir_count;
      held      = 0;
      got       = 1'b0;
      stall_bad = 1'b0;
      EnterBtn  = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clock);
         if (InputReady) begin
            got = 1'b1;
            chk({tag, "_stall_in_ready"}, {31'b0, Stall}, 32'd0);
            chk({tag, "_datain"}, DataIn, exp);
         end else if (!Stall) begin
            stall_bad = 1'b1;
         end
         @(posedge clock);
         #1;
         held++;
         if (held >= hold) EnterBtn = 1'b0;
      end
      chk({tag, "_ready_seen"}, {31'b0, got}, 32'd1);
      chk({tag, "_stall_held"}, {31'b0, stall_bad}, 32'd0);
      InReq    = 1'b0;
      EnterBtn = 1'b0;
      step(12);
      chk({tag, "_one_pulse"}, 32'(ir_count - start), 32'd1);
      chk({tag, "_datain_held"}, DataIn, exp);
      exp_datain = exp;
      $display("txn input %s switches=%h datain=%h", tag, Switches, DataIn);
   endtask

   initial begin
      logic [SW_W-1:0]   sw;
      logic [DATA_W-1:0] d;
      logic              bad;
      int                start;

      reset_n       = 1'b0;
      outputControl = 1'b0;
      OutData       = '0;
      InReq         = 1'b0;
      EnterBtn      = 1'b0;
      Switches      = '0;
      exp_display   = '0;
      exp_datain    = '0;

      step(3);
      @(negedge clock);
      chk("reset_stall", {31'b0, Stall}, 32'd0);
      chk("reset_ready", {31'b0, InputReady}, 32'd0);
      chk("reset_datain", DataIn, 32'd0);
      chk("reset_display", Display, 32'd0);
      chk("reset_display_valid", {31'b0, DisplayValid}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step(2);

      // Output path, hold, and back-to-back strobes.
      do_output(32'hDEADBEEF);
      OutData = 32'h0BADF00D;
      step(3);
      @(negedge clock);
      chk("display_hold", Display, exp_display);
      chk("display_valid_hold", {31'b0, DisplayValid}, 32'd1);
      outputControl = 1'b1;
      step(1);
      OutData = 32'hA1A1A1A1;
      step(1);
      outputControl = 1'b0;
      OutData       = 32'hB2B2B2B2;
      @(negedge clock);
      chk("b2b_first", Display, 32'hA1A1A1A1);
      step(1);
      @(negedge clock);
      chk("b2b_second", Display, 32'hB2B2B2B2);
      exp_display = 32'hB2B2B2B2;
      $display("txn output back-to-back display=%h", Display);

      // Clean presses, positive and negative switch words.
      start_input(16'h00A5);
      step(3);
      @(negedge clock);
      chk("pending_stall", {31'b0, Stall}, 32'd1);
      chk("pending_no_ready", {31'b0, InputReady}, 32'd0);
      press_and_wait(6, ext_sw(16'h00A5), "in_00a5");
      start_input(16'h80A5);
      step(2);
      press_and_wait(6, ext_sw(16'h80A5), "in_80a5");

      // Bouncing button: never stable long enough to register.
      start_input(16'h1234);
      bad = 1'b0;
      for (int c = 0; c < 24; c++) begin
         EnterBtn = ((c / 2) % 2) == 0;
         @(negedge clock);
         if (InputReady || !Stall) bad = 1'b1;
         @(posedge clock);
         #1;
      end
      EnterBtn = 1'b0;
      chk("bounce_ignored", {31'b0, bad}, 32'd0);
      chk("bounce_datain_held", DataIn, exp_datain);
      $display("txn bounce rejected");
      step(2);
      press_and_wait(7, ext_sw(16'h1234), "after_bounce");

      // Button already held when the request arrives.
      EnterBtn = 1'b1;
      step(10);
      sw = SW_W'($urandom);
      start_input(sw);
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) EnterBtn = 1'b0;
         @(negedge clock);
         if (InputReady || !Stall) bad = 1'b1;
         @(posedge clock);
         #1;
      end
      chk("held_button_ignored", {31'b0, bad}, 32'd0);
      $display("txn held button rejected");
      press_and_wait(6, ext_sw(sw), "after_release");

      // Abort: request withdrawn while waiting for the press.
      start = ir_count;
      start_input(SW_W'($urandom));
      step(4);
      InReq = 1'b0;
      step(1);
      @(negedge clock);
      chk("abort_stall", {31'b0, Stall}, 32'd0);
      EnterBtn = 1'b1;
      step(8);
      EnterBtn = 1'b0;
      step(8);
      chk("abort_no_ready", 32'(ir_count - start), 32'd0);
      chk("abort_datain", DataIn, exp_datain);
      $display("txn abort datain=%h", DataIn);

      // Output serviced while an input is pending.
      sw = SW_W'($urandom);
      start_input(sw);
      step(3);
      do_output(32'h12345678);
      chk("concurrent_stall", {31'b0, Stall}, 32'd1);
      press_and_wait(6, ext_sw(sw), "concurrent");

      // Randomized transactions.
      for (int i = 0; i < 5; i++) begin
         sw = SW_W'($urandom);
         d  = $urandom;
         start_input(sw);
         step($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) begin
            do_output(d);
            chk("rand_out_stall", {31'b0, Stall}, 32'd1);
         end
         press_and_wait($urandom_range(6, 10), ext_sw(sw), "rand");
      end
      @(negedge clock);
      chk("rand_display", Display, exp_display);

      // Asynchronous reset while waiting for a press.
      start_input(16'h5A5A);
      step(4);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      exp_display = '0;
      chk("async_reset_stall", {31'b0, Stall}, 32'd0);
      chk("async_reset_ready", {31'b0, InputReady}, 32'd0);
      chk("async_reset_display", Display, exp_display);
      chk("async_reset_valid", {31'b0, DisplayValid}, 32'd0);
      chk("async_reset_datain", DataIn, 32'd0);
      @(posedge clock);
      #1;
      InReq   = 1'b0;
      reset_n = 1'b1;
      step(2);
      @(negedge clock);
      chk("post_reset_stall", {31'b0, Stall}, 32'd0);
      $display("txn async reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
